// File: rtl/bitwise_logic_unit.sv
// Registered bitwise logic unit with valid/ready handshakes and an
// accumulate mode. Each accepted beat computes R = f(A', b) and presents it
// on y one cycle later. A' is either operand a or the internal accumulator.
//
// Ports:
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   in_valid/in_ready   input handshake; in_ready = !out_valid || out_ready
//   op                  operation select (AND/OR/NOT/NOR/NAND/XOR/XNOR/PASS)
//   acc_en, acc_clr     accumulate mode / accumulator clear
//   a, b                operands
//   out_valid/out_ready output handshake
//   y, zero, parity     registered result and its flags
//   beat_cnt            saturating count of accepted beats
module bitwise_logic_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             acc_en,
    input  logic             acc_clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             parity,
    output logic [CNT_W-1:0] beat_cnt
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_NOT  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_XNOR = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] res;
    logic             accept;

    // Ready depends only on output-stage state, never on in_valid.
    assign in_ready = rst_n && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // A' source: accumulator in accumulate mode (forced to zero on a clear).
    always_comb begin
        a_sel = a;
        if (acc_en) begin
            a_sel = acc_clr ? '0 : acc;
        end
    end

    // Pure bitwise op select.
    always_comb begin
        res = '0;
        unique case (op)
            OP_AND:  res = a_sel & b;
            OP_OR:   res = a_sel | b;
            OP_NOT:  res = ~a_sel;
            OP_NOR:  res = ~(a_sel | b);
            OP_NAND: res = ~(a_sel & b);
            OP_XOR:  res = a_sel ^ b;
            OP_XNOR: res = ~(a_sel ^ b);
            OP_PASS: res = b;
            default: res = '0;
        endcase
    end

    // Output stage: load on accept, drop valid on a drain with no new beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y         <= '0;
            zero      <= 1'b0;
            parity    <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            y         <= res;
            zero      <= (res == '0);
            parity    <= ^res;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Accumulator: a clear wins unless the same beat accumulates from zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (accept && acc_en) begin
            acc <= res;
        end else if (acc_clr) begin
            acc <= '0;
        end
    end

    // Saturating accepted-beat counter; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (accept && (beat_cnt != CNT_MAX)) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Bench for bitwise_logic_unit (WIDTH=8, CNT_W=2): directed table and
// sequences from the test plan, then randomized traffic against a model.
module tb_bitwise_logic_unit;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 2;
    localparam int          CNT_SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    op;
    logic          acc_en;
    logic          acc_clr;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  y;
    logic          zero;
    logic          parity;
    logic [CW-1:0] beat_cnt;

    always #5 clk = ~clk;

    bitwise_logic_unit #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .acc_en(acc_en), .acc_clr(acc_clr),
        .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .zero(zero), .parity(parity), .beat_cnt(beat_cnt)
    );

    int checks = 0;
    int failures = 0;

    // Reference state, tracked at transaction level.
    logic [W-1:0] m_y;
    logic [W-1:0] m_acc;
    logic         m_valid;
    logic         m_zero;
    logic         m_par;
    int           m_cnt;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_y;
        logic         exp_zero;
        logic         exp_par;
    } vec_t;

    vec_t sweep[8];
    int   sat_exp[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [2:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] bb);
        case (o)
            3'd0:    return x & bb;
            3'd1:    return x | bb;
            3'd2:    return ~x;
            3'd3:    return ~(x | bb);
            3'd4:    return ~(x & bb);
            3'd5:    return x ^ bb;
            3'd6:    return ~(x ^ bb);
            default: return bb;
        endcase
    endfunction

    // One clock: check in_ready, advance the model, check registered outputs.
    task automatic tick();
        logic         rdy;
        logic         acc_ok;
        logic [W-1:0] ap;
        logic [W-1:0] r;
        #1;
        rdy = rst_n && (!m_valid || out_ready);
        chk("in_ready", 32'(in_ready), 32'(rdy));
        if (!rst_n) begin
            m_y = '0; m_acc = '0; m_valid = 1'b0; m_zero = 1'b0; m_par = 1'b0; m_cnt = 0;
        end else begin
            acc_ok = in_valid && rdy;
            ap = acc_en ? (acc_clr ? '0 : m_acc) : a;
            r  = ref_op(op, ap, b);
            if (acc_ok) begin
                m_y = r;
                m_zero = (r == '0);
                m_par = 1'($countones(r) % 2);
                m_valid = 1'b1;
                m_cnt = (m_cnt + 1 > CNT_SAT) ? CNT_SAT : m_cnt + 1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (acc_ok && acc_en) m_acc = r;
            else if (acc_clr)     m_acc = '0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("y", 32'(y), 32'(m_y));
        chk("zero", 32'(zero), 32'(m_zero));
        chk("parity", 32'(parity), 32'(m_par));
        chk("beat_cnt", 32'(beat_cnt), 32'(m_cnt));
    endtask

    task automatic idle();
        in_valid = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; idle(); out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        sweep[0] = '{3'd0, 8'hA5, 8'h3C, 8'h24, 1'b0, 1'b0};
        sweep[1] = '{3'd1, 8'hA5, 8'h3C, 8'hBD, 1'b0, 1'b0};
        sweep[2] = '{3'd2, 8'hA5, 8'h3C, 8'h5A, 1'b0, 1'b0};
        sweep[3] = '{3'd3, 8'hA5, 8'h3C, 8'h42, 1'b0, 1'b0};
        sweep[4] = '{3'd4, 8'hA5, 8'h3C, 8'hDB, 1'b0, 1'b0};
        sweep[5] = '{3'd5, 8'hA5, 8'h3C, 8'h99, 1'b0, 1'b0};
        sweep[6] = '{3'd6, 8'hA5, 8'h3C, 8'h66, 1'b0, 1'b0};
        sweep[7] = '{3'd7, 8'hA5, 8'h3C, 8'h3C, 1'b0, 1'b0};
        sat_exp = '{1, 2, 3, 3, 3};

        rst_n = 1'b0; op = 3'd0; a = '0; b = '0; out_ready = 1'b1; idle();
        m_y = '0; m_acc = '0; m_valid = 1'b0; m_zero = 1'b0; m_par = 1'b0; m_cnt = 0;

        // Reset / idle
        do_reset();
        #1;
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_y", 32'(y), 32'h00);
        chk("idle_beat_cnt", 32'(beat_cnt), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // Op sweep, back to back
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; op = sweep[i].op; a = sweep[i].a; b = sweep[i].b;
            tick();
            chk("sweep_y", 32'(y), 32'(sweep[i].exp_y));
            chk("sweep_zero", 32'(zero), 32'(sweep[i].exp_zero));
            chk("sweep_parity", 32'(parity), 32'(sweep[i].exp_par));
        end
        idle(); tick();

        // Backpressure: hold 5 cycles, then drain and accept on the same edge
        in_valid = 1'b1; op = 3'd0; a = 8'hFF; b = 8'h12; out_ready = 1'b1;
        tick();
        chk("bp_first_y", 32'(y), 32'h12);
        out_ready = 1'b0; b = 8'h34;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_y", 32'(y), 32'h12);
            chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_y", 32'(y), 32'h34);
        chk("bp_release_valid", 32'(out_valid), 32'd1);
        idle(); tick();
        chk("bp_drain_valid", 32'(out_valid), 32'd0);
        chk("bp_drain_y_hold", 32'(y), 32'h34);

        // Accumulate XOR fold
        in_valid = 1'b1; out_ready = 1'b1; op = 3'd5; a = 8'h55;
        acc_en = 1'b1; acc_clr = 1'b1; b = 8'h0F;
        tick();
        chk("fold_y0", 32'(y), 32'h0F);
        acc_clr = 1'b0; b = 8'hF0;
        tick();
        chk("fold_y1", 32'(y), 32'hFF);
        b = 8'hFF;
        tick();
        chk("fold_y2", 32'(y), 32'h00);
        chk("fold_zero", 32'(zero), 32'd1);
        acc_en = 1'b0; a = 8'h11; b = 8'h22;
        tick();
        chk("fold_plain_y", 32'(y), 32'h33);
        acc_en = 1'b1; op = 3'd1; b = 8'h00;
        tick();
        chk("fold_acc_kept", 32'(y), 32'h00);
        idle(); tick();

        // Counter saturation
        do_reset();
        in_valid = 1'b1; op = 3'd7; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b = 8'(i + 1);
            tick();
            chk("sat_cnt", 32'(beat_cnt), 32'(sat_exp[i]));
        end
        idle(); tick();

        // Mid-stream reset with a held result and a loaded accumulator
        in_valid = 1'b1; acc_en = 1'b1; op = 3'd7; b = 8'h5A; out_ready = 1'b1;
        tick();
        idle(); out_ready = 1'b0;
        tick();
        chk("mid_held_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0; in_valid = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_y", 32'(y), 32'h00);
        chk("mid_rst_cnt", 32'(beat_cnt), 32'd0);
        rst_n = 1'b1; out_ready = 1'b1; acc_en = 1'b1; acc_clr = 1'b0; op = 3'd1; b = 8'h81;
        tick();
        chk("mid_post_or_y", 32'(y), 32'h81);
        idle(); tick();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst_n     = ($urandom_range(0, 31) != 0);
            in_valid  = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
            op        = 3'($urandom_range(0, 7));
            acc_en    = 1'($urandom_range(0, 1));
            acc_clr   = ($urandom_range(0, 7) == 0);
            a         = 8'($urandom);
            b         = 8'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
